// File: rtl/fmul_issue_queue.sv
// Issue queue in front of a combinational single-precision multiplier:
// in-order operand FIFO, one registered result slot, sticky overflow flag.

// Combinational FP32 multiply: mantissa truncated, zero-exponent operands and
// underflowing results flush to signed zero, overflow saturates to infinity.
module fmul (
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] y,
  output logic        ovf
);
  logic [23:0] ma, mb;
  logic [24:0] top;
  logic [9:0]  esum;
  logic [22:0] frac;
  logic        s;

  always_comb begin
    s    = x1[31] ^ x2[31];
    ma   = {1'b1, x1[22:0]};
    mb   = {1'b1, x2[22:0]};
    top  = 25'((48'(ma) * 48'(mb)) >> 23);
    esum = {2'b00, x1[30:23]} + {2'b00, x2[30:23]} + {9'd0, top[24]};
    frac = top[24] ? top[23:1] : top[22:0];
    y    = {s, 31'd0};
    ovf  = 1'b0;
    // esum carries the doubled bias: valid biased exponent is esum-127 in 1..254
    if (x1[30:23] == 8'd0 || x2[30:23] == 8'd0) begin
      y = {s, 31'd0};
    end else if (esum >= 10'd382) begin
      y   = {s, 8'hff, 23'd0};
      ovf = 1'b1;
    end else if (esum <= 10'd127) begin
      y = {s, 31'd0};
    end else begin
      y = {s, 8'(esum - 10'd127), frac};
    end
  end
endmodule

module fmul_issue_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_x1,
  input  logic [31:0]                in_x2,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_y,
  output logic                       out_ovf,
  output logic [TAG_W-1:0]           out_tag,
  output logic                       ovf_sticky,
  input  logic                       clr_sticky,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]      mem_x1  [DEPTH];
  logic [31:0]      mem_x2  [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];
  logic [AW-1:0]    head, tail;
  logic             push, load;
  logic [31:0]      fm_y;
  logic             fm_ovf;

  assign in_ready = !rst && (count != FULL);
  assign push     = in_valid && in_ready;
  assign load     = (count != '0) && (!out_valid || out_ready);

  fmul u_fmul (
    .x1  (mem_x1[head]),
    .x2  (mem_x2[head]),
    .y   (fm_y),
    .ovf (fm_ovf)
  );

  always_ff @(posedge clk) begin
    if (push) begin
      mem_x1[tail]  <= in_x1;
      mem_x2[tail]  <= in_x2;
      mem_tag[tail] <= in_tag;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      out_valid  <= 1'b0;
      out_y      <= '0;
      out_ovf    <= 1'b0;
      out_tag    <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (push) tail <= tail + AW'(1);
      count <= count + CW'(push) - CW'(load);
      if (load) begin
        head      <= head + AW'(1);
        out_y     <= fm_y;
        out_ovf   <= fm_ovf;
        out_tag   <= mem_tag[head];
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (load && fm_ovf) ovf_sticky <= 1'b1;
      else if (clr_sticky) ovf_sticky <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fmul_issue_queue.sv
// Bench for fmul_issue_queue: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fmul_issue_queue;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 5;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic             clr_sticky = 1'b0;
  logic [31:0]      in_x1 = '0;
  logic [31:0]      in_x2 = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             in_ready, out_valid, out_ovf, ovf_sticky;
  logic [31:0]      out_y;
  logic [TAG_W-1:0] out_tag;
  logic [CW-1:0]    count;

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  fmul_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x1(in_x1), .in_x2(in_x2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_ovf(out_ovf), .out_tag(out_tag),
    .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky),
    .count(count)
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] to_dbl(logic [31:0] a);
    return {a[31], 11'(int'(a[30:23]) + 896), a[22:0], 29'd0};
  endfunction

  // {ovf, y}: exact product in double, then truncated/clamped to single
  function automatic logic [32:0] fmul_model(logic [31:0] a, logic [31:0] b);
    real         p;
    logic [63:0] d;
    int          ex;
    logic        s;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {1'b0, s, 31'd0};
    p  = $bitstoreal(to_dbl(a)) * $bitstoreal(to_dbl(b));
    d  = $realtobits(p);
    ex = int'(d[62:52]) - 1023;
    if (ex > 127)  return {1'b1, s, 8'hff, 23'd0};
    if (ex < -126) return {1'b0, s, 31'd0};
    return {1'b0, s, 8'(ex + 127), d[51:29]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 3))
      0:       ;
      1:       v[30:23] = 8'($urandom_range(110, 144));
      2:       v[30:23] = 8'($urandom_range(230, 255));
      default: v[30:23] = 8'($urandom_range(0, 8));
    endcase
    return v;
  endfunction

  typedef struct packed {
    logic [31:0]      x1;
    logic [31:0]      x2;
    logic [TAG_W-1:0] tag;
  } op_t;

  op_t              q[$];
  logic             m_valid = 1'b0;
  logic             m_ovf = 1'b0;
  logic             m_sticky = 1'b0;
  logic [31:0]      m_y = '0;
  logic [TAG_W-1:0] m_tag = '0;

  always @(posedge clk) begin : model_update
    bit          push, load;
    op_t         h;
    logic [32:0] r;
    if (rst) begin
      q.delete();
      m_valid = 1'b0; m_ovf = 1'b0; m_sticky = 1'b0; m_y = '0; m_tag = '0;
    end else begin
      push = in_valid && (q.size() != DEPTH);
      load = (q.size() != 0) && (!m_valid || out_ready);
      if (load) begin
        h = q.pop_front();
        r = fmul_model(h.x1, h.x2);
        m_y = r[31:0]; m_ovf = r[32]; m_tag = h.tag; m_valid = 1'b1;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      if (load && r[32]) m_sticky = 1'b1;
      else if (clr_sticky) m_sticky = 1'b0;
      if (push) q.push_back(op_t'{x1: in_x1, x2: in_x2, tag: in_tag});
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready",   in_ready,   !rst && (q.size() != DEPTH));
      chk("count",      count,      64'(q.size()));
      chk("out_valid",  out_valid,  m_valid);
      chk("out_y",      out_y,      m_y);
      chk("out_ovf",    out_ovf,    m_ovf);
      chk("out_tag",    out_tag,    m_tag);
      chk("ovf_sticky", ovf_sticky, m_sticky);
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(bit v, logic [31:0] a, logic [31:0] b, logic [TAG_W-1:0] t);
    in_valid = v; in_x1 = a; in_x2 = b; in_tag = t;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [TAG_W-1:0] tg;

    rst = 1'b1;
    step(2);
    started = 1'b1;
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_sticky", ovf_sticky, 0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", in_ready, 1);

    chk("model_2x3",  fmul_model(32'h40000000, 32'h40400000), {1'b0, 32'h40C00000});
    chk("model_ovf",  fmul_model(32'h7F000000, 32'h7F000000), {1'b1, 32'h7F800000});
    chk("model_neg",  fmul_model(32'hBF800000, 32'h40000000), {1'b0, 32'hC0000000});
    chk("model_zero", fmul_model(32'h00000000, 32'h40000000), 33'h0);
    chk("model_udf",  fmul_model(32'h00800000, 32'h00800000), 33'h0);

    // single op latency
    out_ready = 1'b1;
    drive(1, 32'h40000000, 32'h40400000, 5'd3);
    step();
    drive(0, '0, '0, '0);
    step();
    chk("lat_valid", out_valid, 1);
    chk("lat_y", out_y, 32'h40C00000);
    chk("lat_tag", out_tag, 3);
    chk("lat_ovf", out_ovf, 0);
    step();
    chk("lat_valid_drop", out_valid, 0);

    // back-to-back
    drive(1, 32'h3F800000, 32'h3F800000, 5'd1); step();
    drive(1, 32'h40000000, 32'h40000000, 5'd2); step();
    chk("b2b_y1", out_y, 32'h3F800000); chk("b2b_t1", out_tag, 1);
    drive(1, 32'hBF800000, 32'h40000000, 5'd3); step();
    chk("b2b_y2", out_y, 32'h40800000); chk("b2b_t2", out_tag, 2);
    drive(0, '0, '0, '0); step();
    chk("b2b_y3", out_y, 32'hC0000000); chk("b2b_t3", out_tag, 3);
    chk("b2b_v3", out_valid, 1);
    step();
    chk("b2b_end", out_valid, 0);

    // fill with writeback stalled
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1, rand_op(), rand_op(), TAG_W'(10 + i));
      step();
    end
    drive(0, '0, '0, '0);
    chk("full_count", count, DEPTH);
    chk("full_in_ready", in_ready, 0);
    chk("full_valid", out_valid, 1);
    chk("full_tag", out_tag, 10);
    step(2);
    chk("hold_tag", out_tag, 10);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("drain_tag", out_tag, 64'(10 + i));
      chk("drain_valid", out_valid, 1);
    end
    step();
    chk("drain_done_valid", out_valid, 0);
    chk("drain_done_count", count, 0);

    // sticky overflow
    drive(1, 32'h7F000000, 32'h7F000000, 5'd7); step();
    drive(0, '0, '0, '0); step();
    chk("ovf_y", out_y, 32'h7F800000);
    chk("ovf_flag", out_ovf, 1);
    chk("ovf_sticky_set", ovf_sticky, 1);
    clr_sticky = 1'b1; step(); clr_sticky = 1'b0;
    chk("ovf_sticky_clr", ovf_sticky, 0);
    drive(1, 32'h7F000000, 32'h7F400000, 5'd8); step();
    drive(0, '0, '0, '0);
    clr_sticky = 1'b1; step(); clr_sticky = 1'b0;
    chk("ovf_set_wins", ovf_sticky, 1);
    step();
    chk("ovf_sticky_hold", ovf_sticky, 1);

    // simultaneous push and load, then wrap-around
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, rand_op(), rand_op(), TAG_W'(20 + i));
      step();
    end
    chk("pl_pre_count", count, 2);
    chk("pl_pre_valid", out_valid, 1);
    out_ready = 1'b1;
    drive(1, rand_op(), rand_op(), 5'd23);
    step();
    chk("pl_count_same", count, 2);
    tg = 5'd24;
    for (int i = 0; i < 3 * DEPTH + 4; i++) begin
      drive(1, rand_op(), rand_op(), tg);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
      if (in_valid && !rst) tg = tg + 1'b1;
    end
    drive(0, '0, '0, '0);
    out_ready = 1'b1;
    step(DEPTH + 3);
    chk("wrap_drain_count", count, 0);
    chk("wrap_drain_valid", out_valid, 0);

    // reset mid-operation
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h7F000000, 32'h7F000000, TAG_W'(i));
      step();
    end
    drive(0, '0, '0, '0);
    chk("mid_count", count, 3);
    chk("mid_valid", out_valid, 1);
    chk("mid_sticky", ovf_sticky, 1);
    rst = 1'b1;
    step();
    chk("mid_rst_count", count, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sticky", ovf_sticky, 0);
    chk("mid_rst_y", out_y, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("no_stale", out_valid, 0);
    end

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      out_ready  = ($urandom_range(0, 9) < 6);
      clr_sticky = ($urandom_range(0, 9) == 0);
      drive($urandom_range(0, 9) < 7, rand_op(), rand_op(), TAG_W'($urandom));
      step();
    end
    rst = 1'b0; clr_sticky = 1'b0; out_ready = 1'b1;
    drive(0, '0, '0, '0);
    step(DEPTH + 3);
    chk("final_count", count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
